// File: rtl/btn_event_pkg.sv
// Shared event kind codes and repeat-timer state encoding for the button event path.
package btn_event_pkg;

  localparam logic [1:0] EV_PRESS   = 2'd0;
  localparam logic [1:0] EV_REPEAT  = 2'd1;
  localparam logic [1:0] EV_RELEASE = 2'd2;

  typedef enum logic [1:0] {
    T_IDLE   = 2'd0,
    T_DELAY  = 2'd1,
    T_REPEAT = 2'd2
  } tmr_state_t;

  // Index width that stays legal for a single-button bank.
  function automatic int unsigned btn_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_repeat_timer.sv
// Per-button auto-repeat timer: one-cycle rep_pulse REPEAT_DELAY cycles after the press, then every
// REPEAT_PERIOD cycles while held; pulse is combinational in the firing cycle, no backpressure.
module btn_repeat_timer
  import btn_event_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000,
  parameter int unsigned CNT_W         = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic db,
  input  logic rise,
  output logic rep_pulse
);

  localparam int unsigned DLY_M1 = (REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY - 1;
  localparam int unsigned PER_M1 = (REPEAT_PERIOD == 0) ? 0 : REPEAT_PERIOD - 1;
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(DLY_M1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PER_M1);

  tmr_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= T_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rep_pulse = 1'b0;
    // A zero delay disables auto-repeat entirely; a released button always parks the timer.
    if (REPEAT_DELAY == 0 || !db) begin
      state_d = T_IDLE;
      cnt_d   = '0;
    end else if (rise) begin
      state_d = T_DELAY;
      cnt_d   = '0;
    end else begin
      case (state_q)
        T_DELAY: begin
          if (cnt_q == DELAY_LAST) begin
            rep_pulse = 1'b1;
            cnt_d     = '0;
            state_d   = T_REPEAT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        T_REPEAT: begin
          if (cnt_q == PERIOD_LAST) begin
            rep_pulse = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = T_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_event_gen.sv
// Debounced button levels -> PRESS/REPEAT(/RELEASE with BTN_RELEASE_EVENT_EN) events; 1-cycle press latency.
// One pending slot per button; presented event held until ev_ready, colliding events dropped and flagged in ovf.
module button_event_gen
  import btn_event_pkg::*;
#(
  parameter  int unsigned N_BTN         = 5,
  parameter  int unsigned REPEAT_DELAY  = 50_000_000,
  parameter  int unsigned REPEAT_PERIOD = 10_000_000,
  parameter  int unsigned CNT_W         = 26,
  localparam int unsigned BTN_W         = btn_w(N_BTN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] db,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [BTN_W-1:0] ev_btn,
  output logic [1:0]       ev_kind,
  output logic             ovf,
  input  logic             ovf_clr
);

  logic [N_BTN-1:0]      db_q;
  logic [N_BTN-1:0]      rise;
  logic [N_BTN-1:0]      rep_pulse;
  logic [N_BTN-1:0]      new_vld;
  logic [N_BTN-1:0][1:0] new_kind;
  logic [N_BTN-1:0]      pend_q, pend_d;
  logic [N_BTN-1:0][1:0] kind_q, kind_d;
  logic [N_BTN-1:0]      take;
  logic [N_BTN-1:0]      drop;
  logic [BTN_W-1:0]      first_btn;
  logic [BTN_W-1:0]      sel;
  logic [BTN_W-1:0]      lock_btn_q;
  logic                  lock_q;
  logic                  acc;
  logic                  ovf_q;

  assign rise = db & ~db_q;

`ifdef BTN_RELEASE_EVENT_EN
  logic [N_BTN-1:0] fall;
  assign fall = ~db & db_q;
`endif

  for (genvar g = 0; g < N_BTN; g++) begin : g_tmr
    btn_repeat_timer #(
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .CNT_W        (CNT_W)
    ) u_tmr (
      .clk      (clk),
      .reset    (reset),
      .db       (db[g]),
      .rise     (rise[g]),
      .rep_pulse(rep_pulse[g])
    );
  end

  // Rise, repeat and fall are mutually exclusive per button, so at most one new event each.
  always_comb begin
    new_vld  = '0;
    new_kind = '0;
    for (int i = 0; i < N_BTN; i++) begin
      new_vld[i]  = rise[i] | rep_pulse[i];
      new_kind[i] = rise[i] ? EV_PRESS : EV_REPEAT;
`ifdef BTN_RELEASE_EVENT_EN
      if (fall[i]) begin
        new_vld[i]  = 1'b1;
        new_kind[i] = EV_RELEASE;
      end
`endif
    end
  end

  always_comb begin
    first_btn = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (pend_q[i]) first_btn = BTN_W'(i);
    end
  end

  // A stalled event keeps its button until accepted, even if a lower index becomes pending.
  assign sel      = lock_q ? lock_btn_q : first_btn;
  assign ev_valid = |pend_q;
  assign ev_btn   = sel;
  assign ev_kind  = kind_q[sel];
  assign acc      = ev_valid & ev_ready;
  assign ovf      = ovf_q;

  always_comb begin
    take   = '0;
    pend_d = pend_q;
    kind_d = kind_q;
    drop   = '0;
    for (int i = 0; i < N_BTN; i++) begin
      take[i] = acc && (sel == BTN_W'(i));
      if (new_vld[i]) begin
        if (pend_q[i] && !take[i]) begin
          drop[i] = 1'b1;
        end else begin
          pend_d[i] = 1'b1;
          kind_d[i] = new_kind[i];
        end
      end else if (take[i]) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_q       <= '0;
      pend_q     <= '0;
      kind_q     <= '0;
      lock_q     <= 1'b0;
      lock_btn_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      db_q       <= db;
      pend_q     <= pend_d;
      kind_q     <= kind_d;
      lock_q     <= ev_valid & ~ev_ready;
      lock_btn_q <= sel;
      if (|drop) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

endmodule
